// File: rtl/ncu_dmu_pio_sender_if.sv
// PIO sender bus bundle: NCU request queue side, DMU header/payload side,
// credit returns and credit status. The master modport is the sender itself.
interface ncu_dmu_pio_sender_if;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [35:0] req_addr;
  logic [7:0]  req_bmask;
  logic [63:0] req_wdata;
  logic        ncu_dmu_pio_hdr_vld;
  logic [63:0] ncu_dmu_pio_data;
  logic        dmu_ncu_wrack_vld;
  logic [3:0]  dmu_ncu_wrack_tag;
  logic        rd_ret_vld;
  logic [3:0]  rd_ret_tag;
  logic [4:0]  credit_avail;
  logic        cred_err;

  modport master (
    input  req_vld, req_wr, req_addr, req_bmask, req_wdata,
    input  dmu_ncu_wrack_vld, dmu_ncu_wrack_tag, rd_ret_vld, rd_ret_tag,
    output req_rdy, ncu_dmu_pio_hdr_vld, ncu_dmu_pio_data,
    output credit_avail, cred_err
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_bmask, req_wdata,
    output dmu_ncu_wrack_vld, dmu_ncu_wrack_tag, rd_ret_vld, rd_ret_tag,
    input  req_rdy, ncu_dmu_pio_hdr_vld, ncu_dmu_pio_data,
    input  credit_avail, cred_err
  );
endinterface

// File: rtl/ncu_dmu_pio_sender.sv
// NCU -> DMU PIO sender with a 16-entry credit pool.
// Each accepted request becomes one header cycle, followed by one payload
// cycle for writes. Credits return via DMU write acks or read completions.
// Optional build macro NCU_PIO_CREDIT_CHK_EN: tracks the credit type and
// flags (and ignores) returns that do not match a busy credit of that type.
//
// state      | meaning
// IDLE       | waiting for a request and a free credit
// HDR        | driving the header word for the captured request
// PAYLOAD    | driving the write payload word
module ncu_dmu_pio_sender (
  input logic                   iol2clk,
  input logic                   rst,
  ncu_dmu_pio_sender_if.master  pio
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;

  state_t      state, state_nxt;
  logic [15:0] busy, busy_nxt;
  logic [4:0]  avail_q, avail_nxt, busy_cnt;
  logic [3:0]  alloc_cid;
  logic        accept;

  logic        cap_wr;
  logic [3:0]  cap_cid;
  logic [35:0] cap_addr;
  logic [7:0]  cap_bmask;
  logic [63:0] cap_wdata;

`ifdef NCU_PIO_CREDIT_CHK_EN
  logic [15:0] rd_type, rd_type_nxt;
  logic        err_q, err_nxt;
`endif

  // Ready looks only at registered state; held low while reset is applied.
  assign pio.req_rdy      = !rst && (state == ST_IDLE) && !(&busy);
  assign accept           = pio.req_vld && pio.req_rdy;
  assign pio.credit_avail = rst ? 5'd16 : avail_q;

`ifdef NCU_PIO_CREDIT_CHK_EN
  assign pio.cred_err = err_q && !rst;
`else
  assign pio.cred_err = 1'b0;
`endif

  // Lowest-numbered free credit, taken from the pool before same-cycle returns.
  always_comb begin
    alloc_cid = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!busy[i]) alloc_cid = 4'(i);
    end
  end

  // Next pool contents: apply returns first, then the new allocation.
  always_comb begin
    busy_nxt = busy;
`ifdef NCU_PIO_CREDIT_CHK_EN
    rd_type_nxt = rd_type;
    err_nxt     = 1'b0;
    if (pio.dmu_ncu_wrack_vld && pio.rd_ret_vld &&
        (pio.dmu_ncu_wrack_tag == pio.rd_ret_tag)) begin
      err_nxt = 1'b1;
    end else begin
      if (pio.dmu_ncu_wrack_vld) begin
        if (busy[pio.dmu_ncu_wrack_tag] && !rd_type[pio.dmu_ncu_wrack_tag]) begin
          busy_nxt[pio.dmu_ncu_wrack_tag] = 1'b0;
        end else begin
          err_nxt = 1'b1;
        end
      end
      if (pio.rd_ret_vld) begin
        if (busy[pio.rd_ret_tag] && rd_type[pio.rd_ret_tag]) begin
          busy_nxt[pio.rd_ret_tag] = 1'b0;
        end else begin
          err_nxt = 1'b1;
        end
      end
    end
`else
    if (pio.dmu_ncu_wrack_vld) busy_nxt[pio.dmu_ncu_wrack_tag] = 1'b0;
    if (pio.rd_ret_vld)        busy_nxt[pio.rd_ret_tag] = 1'b0;
`endif
    if (accept) begin
      busy_nxt[alloc_cid] = 1'b1;
`ifdef NCU_PIO_CREDIT_CHK_EN
      rd_type_nxt[alloc_cid] = !pio.req_wr;
`endif
    end
  end

  // Free-credit count derived from the post-update pool.
  always_comb begin
    busy_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      busy_cnt = busy_cnt + {4'd0, busy_nxt[i]};
    end
    avail_nxt = 5'd16 - busy_cnt;
  end

  // Credit pool, free count and error pulse registers.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      busy    <= 16'd0;
      avail_q <= 5'd16;
`ifdef NCU_PIO_CREDIT_CHK_EN
      rd_type <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      busy    <= busy_nxt;
      avail_q <= avail_nxt;
`ifdef NCU_PIO_CREDIT_CHK_EN
      rd_type <= rd_type_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

  // Capture the request fields and its credit ID at accept.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      cap_wr    <= 1'b0;
      cap_cid   <= 4'd0;
      cap_addr  <= 36'd0;
      cap_bmask <= 8'd0;
      cap_wdata <= 64'd0;
    end else if (accept) begin
      cap_wr    <= pio.req_wr;
      cap_cid   <= alloc_cid;
      cap_addr  <= pio.req_addr;
      cap_bmask <= pio.req_bmask;
      cap_wdata <= pio.req_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge iol2clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_HDR;
      ST_HDR:     state_nxt = cap_wr ? ST_PAYLOAD : ST_IDLE;
      ST_PAYLOAD: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: header word, payload word, or quiet bus.
  always_comb begin
    pio.ncu_dmu_pio_hdr_vld = 1'b0;
    pio.ncu_dmu_pio_data    = 64'h0;
    if (!rst) begin
      case (state)
        ST_HDR: begin
          pio.ncu_dmu_pio_hdr_vld = 1'b1;
          pio.ncu_dmu_pio_data    = {3'b000, !cap_wr, cap_cid, 8'h00, cap_bmask,
                                     4'h0, cap_addr};
        end
        ST_PAYLOAD: pio.ncu_dmu_pio_data = cap_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ncu_dmu_pio_sender.sv
// Directed plus randomized bench for ncu_dmu_pio_sender against a credit-pool
// reference model kept as plain arrays. Honors NCU_PIO_CREDIT_CHK_EN.
module tb_ncu_dmu_pio_sender;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bit mb[16];   // model: credit busy
  bit mt[16];   // model: credit holds a read

  ncu_dmu_pio_sender_if pio();

  ncu_dmu_pio_sender dut (.iol2clk(clk), .rst(rst), .pio(pio));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 16; i++) if (!mb[i]) return i;
    return -1;
  endfunction

  function automatic int nbusy();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(mb[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin mb[i] = 0; mt[i] = 0; end
  endtask

  task automatic model_ret(input bit wv, input logic [3:0] wt, input bit rv,
                           input logic [3:0] rt, output bit err);
    bit okw, okr;
    err = 0;
`ifdef NCU_PIO_CREDIT_CHK_EN
    if (wv && rv && wt == rt) begin
      err = 1;
    end else begin
      okw = mb[wt] && !mt[wt];
      okr = mb[rt] && mt[rt];
      if (wv && !okw) err = 1;
      if (rv && !okr) err = 1;
      if (wv && okw) mb[wt] = 0;
      if (rv && okr) mb[rt] = 0;
    end
`else
    okw = 0; okr = 0;
    if (wv) mb[wt] = 0;
    if (rv) mb[rt] = 0;
`endif
  endtask

  task automatic idle_inputs();
    pio.req_vld = 0; pio.req_wr = 0; pio.req_addr = '0; pio.req_bmask = '0;
    pio.req_wdata = '0; pio.dmu_ncu_wrack_vld = 0; pio.dmu_ncu_wrack_tag = '0;
    pio.rd_ret_vld = 0; pio.rd_ret_tag = '0;
  endtask

  // Entered at #1 after a posedge with the DUT idle and a free credit.
  task automatic send(input bit wr, input logic [35:0] addr, input logic [7:0] bm,
                      input logic [63:0] wd, input bit wv, input logic [3:0] wt,
                      input bit rv, input logic [3:0] rt);
    int cid; bit err; logic [63:0] hdr;
    cid = lowest_free();
    pio.req_vld = 1; pio.req_wr = wr; pio.req_addr = addr; pio.req_bmask = bm;
    pio.req_wdata = wd; pio.dmu_ncu_wrack_vld = wv; pio.dmu_ncu_wrack_tag = wt;
    pio.rd_ret_vld = rv; pio.rd_ret_tag = rt;
    @(negedge clk);
    check("req_rdy_before_accept", 64'(pio.req_rdy), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    model_ret(wv, wt, rv, rt, err);
    mb[cid] = 1; mt[cid] = !wr;
    hdr = (64'(!wr) << 60) + (64'(cid) << 56) + (64'(bm) << 40) + 64'(addr);
    @(negedge clk);
    check("hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd1);
    check("hdr_data", pio.ncu_dmu_pio_data, hdr);
    check("credit_avail_at_hdr", 64'(pio.credit_avail), 64'(16 - nbusy()));
    check("cred_err_at_hdr", 64'(pio.cred_err), 64'(err));
    @(posedge clk); #1;
    if (wr) begin
      @(negedge clk);
      check("payload_hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd0);
      check("payload_data", pio.ncu_dmu_pio_data, wd);
      check("payload_req_rdy", 64'(pio.req_rdy), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_ret(input bit wv, input logic [3:0] wt, input bit rv, input logic [3:0] rt);
    bit err;
    pio.dmu_ncu_wrack_vld = wv; pio.dmu_ncu_wrack_tag = wt;
    pio.rd_ret_vld = rv; pio.rd_ret_tag = rt;
    @(posedge clk); #1;
    idle_inputs();
    model_ret(wv, wt, rv, rt, err);
    @(negedge clk);
    check("credit_avail_after_ret", 64'(pio.credit_avail), 64'(16 - nbusy()));
    check("cred_err_after_ret", 64'(pio.cred_err), 64'(err));
    @(posedge clk); #1;
    @(negedge clk);
    check("cred_err_pulse_end", 64'(pio.cred_err), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle();
    @(negedge clk);
    check("idle_hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd0);
    check("idle_data", pio.ncu_dmu_pio_data, 64'd0);
    check("idle_req_rdy", 64'(pio.req_rdy), 64'(nbusy() < 16));
    @(posedge clk); #1;
  endtask

  task automatic pick_returns(output bit wv, output logic [3:0] wt,
                              output bit rv, output logic [3:0] rt);
    int q[$]; int a, b;
    wv = 0; rv = 0; wt = '0; rt = '0;
    for (int i = 0; i < 16; i++) if (mb[i]) q.push_back(i);
    if (q.size() == 0 || $urandom_range(0, 2) == 0) return;
    a = q[$urandom_range(0, q.size() - 1)];
    if (mt[a]) begin rv = 1; rt = 4'(a); end else begin wv = 1; wt = 4'(a); end
    if ($urandom_range(0, 1) == 1) begin
      b = q[$urandom_range(0, q.size() - 1)];
      if (b != a && mt[b] != mt[a]) begin
        if (mt[b]) begin rv = 1; rt = 4'(b); end else begin wv = 1; wt = 4'(b); end
      end
    end
  endtask

  initial begin
    bit wv, rv; logic [3:0] wt, rt; int cid;
    idle_inputs();
    model_clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_rdy", 64'(pio.req_rdy), 64'd0);
    check("rst_hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd0);
    check("rst_data", pio.ncu_dmu_pio_data, 64'd0);
    check("rst_credit_avail", 64'(pio.credit_avail), 64'd16);
    check("rst_cred_err", 64'(pio.cred_err), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("req_rdy_after_rst", 64'(pio.req_rdy), 64'd1);
    @(posedge clk); #1;

    // Write then read: cid 0 then cid 1.
    send(1, 36'h8_0000_0100, 8'hFF, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
    check_idle();
    send(0, 36'h8_0000_0200, 8'h0F, 64'h0, 0, 0, 0, 0);
    check_idle();

    // Returns in the accept cycle: cid 2 allocated, +2/-1 on credits.
    send(0, 36'h1_2345_6789, 8'h3C, 64'h0, 1, 4'd0, 1, 4'd1);
    check_idle();

    // Return to a free credit.
    do_ret(1, 4'd3, 0, 4'd0);

    // Fill the pool with reads.
    while (nbusy() < 16) begin
      send(0, 36'($urandom), 8'($urandom), 64'h0, 0, 0, 0, 0);
    end
    pio.req_vld = 1; pio.req_wr = 0; pio.req_addr = 36'h0_0000_0ABC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_req_rdy", 64'(pio.req_rdy), 64'd0);
      check("full_hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd0);
      check("full_credit_avail", 64'(pio.credit_avail), 64'd0);
      @(posedge clk); #1;
    end
    idle_inputs();
    do_ret(0, 4'd0, 1, 4'd5);
    cid = lowest_free();
    send(0, 36'h0_0000_0ABC, 8'h01, 64'h0, 0, 0, 0, 0);
    check("reuse_cid", 64'(cid), 64'd5);

    // Randomized traffic with legal returns.
    for (int it = 0; it < 80; it++) begin
      pick_returns(wv, wt, rv, rt);
      if (nbusy() < 16 && $urandom_range(0, 3) != 0) begin
        send(1'($urandom), 36'($urandom) ^ (36'($urandom) << 20), 8'($urandom),
             {$urandom, $urandom}, wv, wt, rv, rt);
      end else if (wv || rv) begin
        do_ret(wv, wt, rv, rt);
      end else begin
        check_idle();
      end
    end

    // Reset in the middle of a write payload.
    if (nbusy() == 16) begin
      if (mt[0]) do_ret(0, 4'd0, 1, 4'd0);
      else       do_ret(1, 4'd0, 0, 4'd0);
    end
    cid = lowest_free();
    pio.req_vld = 1; pio.req_wr = 1; pio.req_addr = 36'h0_0000_0F00;
    pio.req_bmask = 8'hAA; pio.req_wdata = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("pre_rst_hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    @(negedge clk);
    check("mid_rst_data", pio.ncu_dmu_pio_data, 64'd0);
    check("mid_rst_hdr_vld", 64'(pio.ncu_dmu_pio_hdr_vld), 64'd0);
    check("mid_rst_credit_avail", 64'(pio.credit_avail), 64'd16);
    check("mid_rst_req_rdy", 64'(pio.req_rdy), 64'd1);
    @(posedge clk); #1;
    do_ret(1, 4'(cid), 0, 4'd0);
    send(1, 36'h8_0000_0100, 8'hFF, 64'hCAFE_F00D_0000_0001, 0, 0, 0, 0);
    check_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ncu_dmu_pio_sender.md
NCU_DMU_PIO_SENDER -- requirements
Module: ncu_dmu_pio_sender

Interface
REQ-001 SHALL: iol2clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL: req_vld  in  1  PIO request from NCU I/O request queue.
REQ-004 SHALL: req_rdy  out  1  request accepted on a cycle where req_vld && req_rdy.
REQ-005 SHALL: req_wr  in  1  1 = PIO write, 0 = PIO read.
REQ-006 SHALL: req_addr  in  36  PIO physical address.
REQ-007 SHALL: req_bmask  in  8  byte mask.
REQ-008 SHALL: req_wdata  in  64  write payload; sampled at accept, ignored for reads.
REQ-009 SHALL: ncu_dmu_pio_hdr_vld  out  1  header-cycle strobe to DMU.
REQ-010 SHALL: ncu_dmu_pio_data  out  64  header or payload word to DMU.
REQ-011 SHALL: dmu_ncu_wrack_vld / dmu_ncu_wrack_tag  in  1 / 4  write-credit return from DMU.
REQ-012 SHALL: rd_ret_vld / rd_ret_tag  in  1 / 4  read-credit return from the read-completion path.
REQ-013 SHALL: credit_avail  out  5  number of free credits, 0..16.
REQ-014 SHALL: cred_err  out  1  credit-protocol error pulse (see Configuration).

Function
REQ-015 SHALL: 16-entry credit pool, one busy bit and one type bit (1 = read) per credit ID.
REQ-016 SHALL: FSM states IDLE, HDR, PAYLOAD.
REQ-017 SHALL: IDLE -> HDR on accept; HDR -> PAYLOAD if the captured request is a write, else HDR -> IDLE; PAYLOAD -> IDLE unconditionally.
REQ-018 SHALL: req_rdy = (state == IDLE) && (at least one busy bit clear), computed from registered state only.
REQ-019 SHALL: on accept, allocate the lowest-numbered free credit ID, set its busy bit, record its type, and capture addr, bmask, wdata and wr.
REQ-020 SHALL: in HDR, hdr_vld = 1 and data = {3'b0, rd, cid[3:0], 8'b0, bmask[7:0], 4'b0, addr[35:0]}, i.e. bit 60 = read, bits 59:56 = credit ID.
REQ-021 SHALL: in PAYLOAD, hdr_vld = 0 and data = captured wdata; payload always immediately follows its header (1-cycle latency).
REQ-022 SHALL: in IDLE, hdr_vld = 0 and data = 64'h0.
REQ-023 SHALL: a valid wrack or rd_ret clears the busy bit of its tag at the end of that cycle; the freed ID is allocatable from the next cycle.
REQ-024 SHALL: wrack and rd_ret in the same cycle with different tags both free; allocation and free in the same cycle both take effect.
REQ-025 SHALL: credit_avail is registered and equals 16 minus popcount(busy) after all same-cycle updates.
REQ-026 SHALL: when the pool is full, req_rdy = 0 until a return is processed; no request is dropped.
REQ-027 SHALL: accept-to-header latency is 1 cycle; peak throughput is one read per 2 cycles and one write per 3 cycles.

Reset
REQ-028 SHALL: while rst = 1: state = IDLE, all busy and type bits = 0, req_rdy = 0, hdr_vld = 0, data = 0, credit_avail = 16, cred_err = 0.
REQ-029 SHALL: reset asserted mid-header or mid-payload abandons the transfer; no further output for it; returns for pre-reset tags are processed against the cleared pool.
REQ-030 SHALL: req_rdy returns to 1 on the first cycle after rst deasserts.

Configuration
REQ-031 SHALL: with NCU_PIO_CREDIT_CHK_EN defined, cred_err pulses 1 cycle after a return whose tag is not busy, a wrack to a read credit, an rd_ret to a write credit, or wrack and rd_ret with the same tag; an erroneous return does not change pool state.
REQ-032 SHALL: without NCU_PIO_CREDIT_CHK_EN, cred_err is tied to 0, the type bits are absent, and any return clears its tag's busy bit unconditionally.

Verification
REQ-033 SHALL: reset, then a write to addr 36'h8_0000_0100, bmask 8'hFF, wdata 64'hDEAD_BEEF_0123_4567 -> header bit 60 = 0, cid = 0, then payload 64'hDEAD_BEEF_0123_4567 on the next cycle; credit_avail = 15.
REQ-034 SHALL: a read after the write with credit 0 still busy -> header bit 60 = 1, bits 59:56 = 4'h1, no payload cycle, back in IDLE after 1 cycle.
REQ-035 SHALL: 16 reads with no returns -> credit_avail = 0 and req_rdy = 0; rd_ret_tag = 5 -> the next accept uses cid 5.
REQ-036 SHALL: wrack tag 0 and rd_ret tag 1 in the same cycle as a new accept -> credit_avail reflects +2 / -1, allocated cid = lowest free ID before the returns.
REQ-037 SHALL: with NCU_PIO_CREDIT_CHK_EN, wrack tag 3 while credit 3 is free -> cred_err = 1 for exactly one cycle, pool unchanged.
REQ-038 SHALL: rst asserted during PAYLOAD -> data = 0 on the next cycle, credit_avail = 16.
